soc_apb_timer_counter_psc: RTL and testbench

Parametrised next-generation timer counter core for the APB timer.
- Adds a programmable prescaler, continuous/one-shot modes, overflow detection and a run-status flag.
- Sits behind the APB register file, which drives the control and compare inputs and samples the status and pulse outputs for IRQ generation.
- One instance per timer channel.

---
 rtl/soc_apb_timer_counter_psc.sv | 127 ++++++++++++
 tb/tb_soc_apb_timer_counter_psc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/soc_apb_timer_counter_psc.sv
// Timer counter core for one APB timer channel: programmable prescaler,
// continuous/one-shot modes, registered match, overflow and run-status outputs.
module soc_apb_timer_counter_psc #(
   parameter int WIDTH       = 32,
   parameter int PRESC_WIDTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   reset_count_i,
   input  logic                   enable_count_i,
   input  logic                   mode_i,
   input  logic [PRESC_WIDTH-1:0] prescaler_i,
   input  logic [WIDTH-1:0]       compare_value_i,
   output logic [WIDTH-1:0]       counter_value_o,
   output logic                   target_reached_o,
   output logic                   overflow_o,
   output logic                   running_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [WIDTH-1:0]       CNT_ZERO = '0;
   localparam logic [WIDTH-1:0]       CNT_ONE  = WIDTH'(1'b1);
   localparam logic [WIDTH-1:0]       CNT_MAX  = {WIDTH{1'b1}};
   localparam logic [PRESC_WIDTH-1:0] PSC_ZERO = '0;
   localparam logic [PRESC_WIDTH-1:0] PSC_ONE  = PRESC_WIDTH'(1'b1);

   state_t                   state_r;
   state_t                   state_next_s;
   logic [PRESC_WIDTH-1:0]   psc_cnt_r;
   logic [PRESC_WIDTH-1:0]   psc_next_s;
   logic [WIDTH-1:0]         count_r;
   logic [WIDTH-1:0]         count_next_s;
   logic                     target_r;
   logic                     target_next_s;
   logic                     overflow_r;
   logic                     overflow_next_s;
   logic                     running_r;
   logic                     tick_s;

   // >= rather than == keeps the next tick close when prescaler_i is lowered mid-count
   assign tick_s = (psc_cnt_r >= prescaler_i);

   // Next-state, prescaler and counter update; reset_count_i overrides everything
   always_comb begin
      state_next_s    = state_r;
      psc_next_s      = psc_cnt_r;
      count_next_s    = count_r;
      target_next_s   = 1'b0;
      overflow_next_s = 1'b0;
      if (reset_count_i) begin
         state_next_s = ST_IDLE;
         psc_next_s   = PSC_ZERO;
         count_next_s = CNT_ZERO;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (enable_count_i) begin
                  state_next_s = ST_RUN;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (!enable_count_i) begin
                  state_next_s = ST_IDLE;
               end else if (tick_s) begin
                  psc_next_s = PSC_ZERO;
                  if (count_r == compare_value_i) begin
                     count_next_s  = CNT_ZERO;
                     target_next_s = 1'b1;
                     if (mode_i) begin
                        state_next_s = ST_DONE;
                     end else begin
                        state_next_s = ST_RUN;
                     end
                  end else if (count_r == CNT_MAX) begin
                     count_next_s    = CNT_ZERO;
                     overflow_next_s = 1'b1;
                  end else begin
                     count_next_s = count_r + CNT_ONE;
                  end
               end else begin
                  psc_next_s = psc_cnt_r + PSC_ONE;
               end
            end
            ST_DONE: begin
               state_next_s = ST_DONE;
            end
            default: begin
               state_next_s = ST_IDLE;
               psc_next_s   = PSC_ZERO;
               count_next_s = CNT_ZERO;
            end
         endcase
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r    <= ST_IDLE;
         psc_cnt_r  <= PSC_ZERO;
         count_r    <= CNT_ZERO;
         target_r   <= 1'b0;
         overflow_r <= 1'b0;
         running_r  <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         psc_cnt_r  <= psc_next_s;
         count_r    <= count_next_s;
         target_r   <= target_next_s;
         overflow_r <= overflow_next_s;
         running_r  <= (state_next_s == ST_RUN);
      end
   end

   assign counter_value_o  = count_r;
   assign target_reached_o = target_r;
   assign overflow_o       = overflow_r;
   assign running_o        = running_r;

endmodule

// File: tb/tb_soc_apb_timer_counter_psc.sv
// Directed self-checking bench for soc_apb_timer_counter_psc (4-bit counter build
// so the all-ones wrap can be reached quickly).
module tb_soc_apb_timer_counter_psc;

   localparam int WIDTH       = 4;
   localparam int PRESC_WIDTH = 4;

   logic                   clk;
   logic                   rst;
   logic                   reset_count;
   logic                   enable_count;
   logic                   mode;
   logic [PRESC_WIDTH-1:0] prescaler;
   logic [WIDTH-1:0]       compare_value;
   logic [WIDTH-1:0]       counter_value;
   logic                   target_reached;
   logic                   overflow;
   logic                   running;

   int n_checks = 0;
   int n_fail   = 0;

   soc_apb_timer_counter_psc #(
      .WIDTH       (WIDTH),
      .PRESC_WIDTH (PRESC_WIDTH)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .reset_count_i    (reset_count),
      .enable_count_i   (enable_count),
      .mode_i           (mode),
      .prescaler_i      (prescaler),
      .compare_value_i  (compare_value),
      .counter_value_o  (counter_value),
      .target_reached_o (target_reached),
      .overflow_o       (overflow),
      .running_o        (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_count();
      reset_count  = 1'b1;
      enable_count = 1'b0;
      step();
      check("clr_count", counter_value, 0);
      check("clr_run", running, 0);
      reset_count = 1'b0;
   endtask

   initial begin
      int k;
      rst           = 1'b1;
      reset_count   = 1'b0;
      enable_count  = 1'b0;
      mode          = 1'b0;
      prescaler     = 4'd0;
      compare_value = 4'd0;
      step();
      step();
      check("rst_count", counter_value, 0);
      check("rst_tgt", target_reached, 0);
      check("rst_ovf", overflow, 0);
      check("rst_run", running, 0);
      rst = 1'b0;
      step();
      check("post_rst_count", counter_value, 0);
      check("post_rst_run", running, 0);

      // Continuous, prescaler 0, compare 3
      mode = 1'b0; prescaler = 4'd0; compare_value = 4'd3; enable_count = 1'b1;
      for (int n = 1; n <= 13; n++) begin
         step();
         check("a_count", counter_value, (n == 1) ? 0 : (n - 1) % 4);
         check("a_tgt", target_reached, (n >= 5 && (n - 1) % 4 == 0) ? 1 : 0);
         check("a_run", running, 1);
         check("a_ovf", overflow, 0);
      end
      clear_count();

      // Prescaler 2, compare 1: tick every 3 cycles, match period 6
      prescaler = 4'd2; compare_value = 4'd1; enable_count = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         step();
         k = (n >= 4) ? (n - 4) / 3 + 1 : 0;
         check("b_count", counter_value, k % 2);
         check("b_tgt", target_reached, (n >= 4 && (n - 4) % 3 == 0 && k % 2 == 0) ? 1 : 0);
      end
      clear_count();

      // One-shot, compare 5
      mode = 1'b1; prescaler = 4'd0; compare_value = 4'd5; enable_count = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         step();
         check("c_count", counter_value, (n >= 2 && n <= 6) ? n - 1 : 0);
         check("c_tgt", target_reached, (n == 7) ? 1 : 0);
         check("c_run", running, (n <= 6) ? 1 : 0);
      end
      reset_count = 1'b1;
      step();
      check("c_clr_run", running, 0);
      check("c_clr_count", counter_value, 0);
      reset_count = 1'b0;
      step();
      check("c_restart_run", running, 1);
      check("c_restart_count0", counter_value, 0);
      step();
      check("c_restart_count1", counter_value, 1);
      clear_count();

      // compare = all-ones: match at 15, no overflow
      mode = 1'b0; compare_value = 4'd15; enable_count = 1'b1;
      for (int n = 1; n <= 17; n++) begin
         step();
         check("d1_count", counter_value, (n <= 16) ? n - 1 : 0);
         check("d1_tgt", target_reached, (n == 17) ? 1 : 0);
         check("d1_ovf", overflow, 0);
      end
      clear_count();

      // compare lowered to 3 while count is 10: overflow first, then match at 3
      compare_value = 4'd15; enable_count = 1'b1;
      for (int n = 1; n <= 11; n++) step();
      check("d2_at10", counter_value, 10);
      compare_value = 4'd3;
      for (int n = 12; n <= 21; n++) begin
         step();
         check("d2_count", counter_value, (n <= 16) ? n - 1 : (n == 17 || n == 21) ? 0 : n - 17);
         check("d2_ovf", overflow, (n == 17) ? 1 : 0);
         check("d2_tgt", target_reached, (n == 21) ? 1 : 0);
      end
      clear_count();

      // Pause at 7 for 5 cycles, then resume
      compare_value = 4'd15; enable_count = 1'b1;
      for (int n = 1; n <= 8; n++) step();
      check("e_at7", counter_value, 7);
      enable_count = 1'b0;
      for (int n = 1; n <= 5; n++) begin
         step();
         check("e_hold", counter_value, 7);
         check("e_hold_run", running, 0);
         check("e_hold_tgt", target_reached, 0);
         check("e_hold_ovf", overflow, 0);
      end
      enable_count = 1'b1;
      step();
      check("e_resume_run", running, 1);
      check("e_resume_hold", counter_value, 7);
      step();
      check("e_resume_8", counter_value, 8);
      check("e_resume_tgt", target_reached, 0);
      clear_count();

      // reset_count in the same cycle as a match tick
      compare_value = 4'd2; enable_count = 1'b1;
      for (int n = 1; n <= 3; n++) step();
      check("f_at2", counter_value, 2);
      reset_count = 1'b1;
      step();
      check("f_clr_count", counter_value, 0);
      check("f_clr_tgt", target_reached, 0);
      check("f_clr_run", running, 0);
      reset_count = 1'b0;
      step();
      check("f_after_tgt", target_reached, 0);
      check("f_after_run", running, 1);
      check("f_after_count", counter_value, 0);
      clear_count();

      // Async reset mid-count, prescaler 2 to expose a stale psc_cnt
      prescaler = 4'd2; compare_value = 4'd15; enable_count = 1'b1;
      for (int n = 1; n <= 8; n++) step();
      check("g_pre_count", counter_value, 2);
      #2;
      rst = 1'b1;
      #1;
      check("g_async_count", counter_value, 0);
      check("g_async_run", running, 0);
      step();
      #2;
      rst = 1'b0;
      #1;
      check("g_rel_count", counter_value, 0);
      check("g_rel_run", running, 0);
      for (int n = 1; n <= 4; n++) begin
         step();
         check("g_restart_count", counter_value, (n == 4) ? 1 : 0);
         check("g_restart_run", running, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
